// File: rtl/adc_sampler_if.sv
// EBI register bus and sample-return strobe shared between the memory unit,
// the bus master and adc_sampler.
interface adc_sampler_if;
  logic [18:0] addr;
  logic [15:0] ebi_data_in;
  logic [15:0] ebi_data_out;
  logic        cs;
  logic        re;
  logic        wr;
  logic        output_sample;
  logic [7:0]  channel_select;
  logic [31:0] sample_data;

  // Handshake: there is no valid/ready pair. A write or read is accepted on every clk
  // edge where cs, a strobe and a matching unit select are high. Read data appears one
  // edge later, and ebi_data_out is 0 otherwise. output_sample is sampled on every edge,
  // and sample_data is valid from the following edge.
  modport master (
    output addr, ebi_data_in, cs, re, wr, output_sample, channel_select,
    input  ebi_data_out, sample_data
  );
  modport slave (
    input  addr, ebi_data_in, cs, re, wr, output_sample, channel_select,
    output ebi_data_out, sample_data
  );
endinterface

// File: rtl/adc_sampler.sv
// Round-robin SPI sequencer for an 8-channel 12-bit ADC. It keeps the latest
// conversion of each channel in a holding register for the sample memory unit.
module adc_sampler #(
    parameter int POSITION     = 200,
    parameter int CLK_DIV      = 4,
    parameter int QUIET_CYCLES = 8
) (
    input  logic         clk,
    input  logic         rst,
    adc_sampler_if.slave bus,
    output logic         adc_sclk,
    output logic         adc_cs_n,
    output logic         adc_mosi,
    input  logic         adc_miso,
    output logic [1:0]   fsm_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, SHIFT = 2'd2, QUIET = 2'd3} state_t;

    localparam int CNT_MAX = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   div_cnt;
    logic [5:0]         half_cnt;
    logic [15:0]        tx_sr, rx_sr;
    logic               sclk_q, cs_act;
    logic               running, stopping, first_frame;
    logic [7:0]         mask;
    logic [2:0]         last_ch, next_ch, cand;
    logic               found;
    logic [15:0]        frame_count;
    logic [31:0]        hold [8];
    logic [15:0]        seq  [8];
    logic               cmd_valid;
    logic [15:0]        cmd_code;

    logic unit_sel, wr_en, rd_en;
    logic cmd_start, cmd_stop, cmd_reset;
    logic div_last, quiet_last, shift_done, launch;
    logic [2:0] rx_ch;
    logic [8:0] sel_off;
    logic       sel_ok;
    logic       unused_bits;

    assign unit_sel   = bus.cs && (bus.addr[15:8] == 8'(POSITION));
    assign wr_en      = unit_sel && bus.wr;
    assign rd_en      = unit_sel && bus.re;
    assign cmd_start  = cmd_valid && (cmd_code == 16'd1);
    assign cmd_stop   = cmd_valid && (cmd_code == 16'd2);
    assign cmd_reset  = cmd_valid && (cmd_code == 16'd5);
    assign div_last   = (div_cnt == CNT_W'(CLK_DIV - 1));
    // QUIET is one short because the IDLE decision cycle also keeps cs_n high.
    assign quiet_last = (div_cnt == CNT_W'(QUIET_CYCLES - 2));
    assign shift_done = (state == SHIFT) && div_last && (half_cnt == 6'd32);
    assign launch     = running && !stopping && !cmd_stop && (mask != 8'd0);
    assign rx_ch      = rx_sr[14:12];
    assign sel_off    = {1'b0, bus.channel_select} - 9'(POSITION);
    assign sel_ok     = (sel_off[8:3] == 6'd0);
    assign unused_bits = &{1'b0, bus.addr[18:16], rx_sr[15]};

    assign adc_sclk  = sclk_q;
    assign adc_cs_n  = ~cs_act;
    assign adc_mosi  = tx_sr[15];
    assign fsm_state = state;

    always_comb begin
        next_ch = last_ch;
        found   = 1'b0;
        cand    = last_ch;
        for (int i = 1; i <= 8; i++) begin
            cand = last_ch + 3'(i);
            if (!found && mask[cand]) begin
                next_ch = cand;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (launch) state_n = SETUP;
            SETUP:   if (div_last) state_n = SHIFT;
            SHIFT:   if (div_last && (half_cnt == 6'd32)) state_n = QUIET;
            QUIET:   if (quiet_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (cmd_reset) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // SHIFT is 33 half-periods: 16 low/high SCLK periods, then a high hold half with cs_n low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt  <= '0;
            half_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            sclk_q   <= 1'b1;
            cs_act   <= 1'b0;
        end else begin
            cs_act <= (state_n == SETUP) || (state_n == SHIFT);
            if ((state_n != state) || ((state == SHIFT) && div_last) || (state == IDLE))
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;

            if (cmd_reset) begin
                sclk_q <= 1'b1;
                tx_sr  <= '0;
            end else if ((state == IDLE) && (state_n == SETUP)) begin
                tx_sr  <= {3'b100, next_ch, 10'b1100010000};
                sclk_q <= 1'b1;
            end else if ((state == SETUP) && div_last) begin
                sclk_q   <= 1'b0;
                half_cnt <= '0;
            end else if ((state == SHIFT) && div_last && (half_cnt != 6'd32)) begin
                half_cnt <= half_cnt + 6'd1;
                if (!half_cnt[0]) begin
                    sclk_q <= 1'b1;
                    rx_sr  <= {rx_sr[14:0], adc_miso};
                end else if (half_cnt != 6'd31) begin
                    sclk_q <= 1'b0;
                    tx_sr  <= {tx_sr[14:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_valid   <= 1'b0;
            cmd_code    <= '0;
            mask        <= '0;
            running     <= 1'b0;
            stopping    <= 1'b0;
            first_frame <= 1'b0;
            last_ch     <= 3'd7;
            frame_count <= '0;
            for (int i = 0; i < 8; i++) begin
                hold[i] <= '0;
                seq[i]  <= '0;
            end
        end else begin
            cmd_valid <= wr_en && (bus.addr[7:0] == 8'd2);
            cmd_code  <= bus.ebi_data_in;
            if (wr_en && (bus.addr[7:0] == 8'd1)) mask <= bus.ebi_data_in[7:0];

            if (cmd_start && !running) begin
                running     <= 1'b1;
                first_frame <= 1'b1;
                last_ch     <= 3'd7;
            end
            if (cmd_stop && running) begin
                if (state == IDLE) running  <= 1'b0;
                else               stopping <= 1'b1;
            end
            if ((state == IDLE) && (state_n == SETUP)) last_ch <= next_ch;

            // The received word reports its own channel, which lags the addressed one by a frame.
            if (shift_done) begin
                frame_count <= frame_count + 16'd1;
                if (first_frame) begin
                    first_frame <= 1'b0;
                end else if (mask[rx_ch]) begin
                    hold[rx_ch] <= {seq[rx_ch] + 16'd1, rx_ch, 1'b0, rx_sr[11:0]};
                    seq[rx_ch]  <= seq[rx_ch] + 16'd1;
                end
            end
            if (((state == QUIET) && quiet_last && stopping) || ((state == IDLE) && stopping)) begin
                running  <= 1'b0;
                stopping <= 1'b0;
            end

            if (cmd_reset) begin
                mask        <= '0;
                running     <= 1'b0;
                stopping    <= 1'b0;
                first_frame <= 1'b0;
                last_ch     <= 3'd7;
                frame_count <= '0;
                for (int i = 0; i < 8; i++) begin
                    hold[i] <= '0;
                    seq[i]  <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.sample_data  <= '0;
            bus.ebi_data_out <= '0;
        end else begin
            if (bus.output_sample && sel_ok) bus.sample_data <= hold[sel_off[2:0]];
            if (rd_en) begin
                case (bus.addr[7:0])
                    8'd1:    bus.ebi_data_out <= {8'd0, mask};
                    8'd3:    bus.ebi_data_out <= {14'd0, stopping, running};
                    8'd4:    bus.ebi_data_out <= frame_count;
                    default: bus.ebi_data_out <= '0;
                endcase
            end else begin
                bus.ebi_data_out <= '0;
            end
        end
    end
endmodule

// File: tb/tb_adc_sampler.sv
// Bench for adc_sampler: SPI ADC model plus a frame-level model of holds,
// sequence numbers and channel order, with random codes and masks.
module tb_adc_sampler;
  localparam int POSITION = 200;
  localparam int CLK_DIV = 4;
  localparam int QUIET_CYCLES = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic adc_sclk, adc_cs_n, adc_mosi;
  logic adc_miso = 1'b0;
  logic [1:0] fsm_state;

  adc_sampler_if bus ();

  adc_sampler #(.POSITION(POSITION), .CLK_DIV(CLK_DIV), .QUIET_CYCLES(QUIET_CYCLES)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n), .adc_mosi(adc_mosi),
    .adc_miso(adc_miso), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ADC model and frame-level reference
  int rise_cnt = 0;
  int fall_cnt = 0;
  logic [15:0] miso_word = '0;
  logic [15:0] mosi_word = '0;
  logic [2:0]  adc_prev_ch = '0;
  logic        fix_code_en = 1'b0;
  logic [11:0] fix_code = '0;
  logic [7:0]  m_mask = '0;
  bit          m_first = 1'b0;
  logic [15:0] m_seq [8];
  logic [31:0] m_hold [8];
  int          m_frames = 0;
  int          m_ctrl_bad = 0;
  logic [2:0]  got_q [$];
  logic [2:0]  exp_q [$];
  int last_fall_cyc = -1;
  int period_last = 0;
  int cs_rise_cyc = -1;
  int min_quiet = 1000;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_seq[i] = '0;
      m_hold[i] = '0;
    end
  endtask

  function automatic logic [2:0] next_set(input logic [7:0] msk, input logic [2:0] last);
    logic [2:0] c;
    for (int k = 1; k <= 8; k++) begin
      c = 3'((int'(last) + k) % 8);
      if (msk[c]) return c;
    end
    return last;
  endfunction

  always @(negedge adc_cs_n) begin
    logic [11:0] code;
    if (last_fall_cyc >= 0) period_last = cyc - last_fall_cyc;
    last_fall_cyc = cyc;
    if (cs_rise_cyc >= 0 && (cyc - cs_rise_cyc) < min_quiet) min_quiet = cyc - cs_rise_cyc;
    code = fix_code_en ? fix_code : 12'($urandom_range(0, 4095));
    miso_word = {1'b0, adc_prev_ch, code};
    adc_miso = miso_word[15];
    rise_cnt = 0;
    fall_cnt = 0;
    mosi_word = '0;
  end

  always @(negedge adc_sclk) begin
    if (adc_cs_n === 1'b0) begin
      if (fall_cnt > 0 && fall_cnt < 16) adc_miso = miso_word[15 - fall_cnt];
      fall_cnt++;
    end
  end

  always @(posedge adc_sclk) begin
    if (adc_cs_n === 1'b0) begin
      mosi_word = {mosi_word[14:0], adc_mosi};
      rise_cnt++;
    end
  end

  always @(posedge adc_cs_n) begin
    logic [2:0] rch;
    cs_rise_cyc = cyc;
    if (rise_cnt == 16) begin
      if (mosi_word[15:13] != 3'b100 || mosi_word[9:0] != 10'b1100010000) m_ctrl_bad++;
      got_q.push_back(mosi_word[12:10]);
      rch = miso_word[14:12];
      if (m_first) m_first = 1'b0;
      else if (m_mask[rch]) begin
        m_seq[rch] = m_seq[rch] + 16'd1;
        m_hold[rch] = {m_seq[rch], rch, 1'b0, miso_word[11:0]};
      end
      adc_prev_ch = mosi_word[12:10];
      m_frames++;
    end
    rise_cnt = 0;
  end

  // driver tasks
  task automatic ebi_write(input logic [7:0] r, input logic [15:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = {3'b000, 8'(POSITION), r}; bus.ebi_data_in = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic ebi_read(input logic [7:0] r, output logic [15:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.re = 1'b1; bus.addr = {3'b000, 8'(POSITION), r};
    @(posedge clk);
    #1 d = bus.ebi_data_out;
    @(negedge clk);
    bus.cs = 1'b0; bus.re = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] sel, output logic [31:0] d);
    @(negedge clk);
    bus.output_sample = 1'b1; bus.channel_select = sel;
    @(posedge clk);
    #1 d = bus.sample_data;
    @(negedge clk);
    bus.output_sample = 1'b0;
  endtask

  task automatic wait_frames(input int target, input string tag);
    int t = 0;
    while (m_frames < target && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(m_frames >= target), 32'd1);
  endtask

  task automatic wait_rise(input int n, input string tag);
    int t = 0;
    while (!(adc_cs_n === 1'b0 && rise_cnt == n) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(t < 2000), 32'd1);
  endtask

  task automatic start_run(input logic [7:0] msk);
    ebi_write(8'd1, {8'd0, msk});
    m_mask = msk;
    got_q.delete();
    ebi_write(8'd2, 16'd1);
    m_first = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [31:0] sd, prev_sd;
    int base;
    bus.addr = '0; bus.ebi_data_in = '0; bus.cs = 1'b0; bus.re = 1'b0; bus.wr = 1'b0;
    bus.output_sample = 1'b0; bus.channel_select = '0;
    model_clear();
    #2 rst = 1'b0;
    #10;
    check("rst_cs_n", 32'(adc_cs_n), 32'd1);
    check("rst_sclk", 32'(adc_sclk), 32'd1);
    check("rst_mosi", 32'(adc_mosi), 32'd0);
    check("rst_sample_data", bus.sample_data, 32'd0);
    check("rst_ebi_out", 32'(bus.ebi_data_out), 32'd0);
    check("rst_fsm_idle", 32'(fsm_state), 32'd0);
    @(negedge clk) rst = 1'b1;

    // EBI read-back
    ebi_write(8'd1, 16'h005A);
    ebi_read(8'd1, rd);  check("rd_mask", 32'(rd), 32'h5A);
    ebi_read(8'd3, rd);  check("rd_status_idle", 32'(rd), 32'd0);
    ebi_read(8'd4, rd);  check("rd_frame_count0", 32'(rd), 32'd0);
    @(posedge clk) #1 check("ebi_out_idle", 32'(bus.ebi_data_out), 32'd0);

    // single channel start/stop
    fix_code_en = 1'b1; fix_code = 12'h123;
    start_run(8'h01);
    wait_frames(m_frames + 2, "wait_two_frames");
    strobe(8'(POSITION), sd);  check("hold0_after_frame2", sd, 32'h0001_0123);
    base = m_frames;
    wait_rise(2, "wait_frame3");
    check("frame_period", 32'(period_last), 32'd144);
    wait_rise(4, "wait_frame3_bit4");
    ebi_write(8'd2, 16'd2);
    ebi_read(8'd3, rd);  check("status_stopping", 32'(rd), 32'd3);
    wait_frames(base + 1, "wait_frame3_end");
    ebi_read(8'd3, rd);  check("status_in_quiet", 32'(rd), 32'd3);
    repeat (20) @(negedge clk);
    ebi_read(8'd3, rd);  check("status_stopped", 32'(rd), 32'd0);
    ebi_read(8'd4, rd);  check("frame_count3", 32'(rd), 32'd3);
    strobe(8'(POSITION), sd);  check("hold0_after_frame3", sd, m_hold[0]);

    // round-robin with wrap on mask 0x85
    ebi_write(8'd2, 16'd5);
    model_clear();
    fix_code_en = 1'b0;
    min_quiet = 1000;
    start_run(8'h85);
    base = m_frames;
    wait_frames(base + 5, "wait_rr_frames");
    ebi_write(8'd2, 16'd2);
    repeat (30) @(negedge clk);
    exp_q = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2};
    check("rr_frame_count", 32'(got_q.size()), 32'd5);
    while (exp_q.size() > 0 && got_q.size() > 0)
      check("rr_channel", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    check("quiet_min_ge8", 32'(min_quiet >= QUIET_CYCLES), 32'd1);
    strobe(8'(POSITION + 2), sd);  check("strobe_ch2", sd, m_hold[2]);
    prev_sd = sd;
    strobe(8'(POSITION + 9), sd);  check("strobe_out_of_range_hi", sd, prev_sd);
    strobe(8'(POSITION - 1), sd);  check("strobe_out_of_range_lo", sd, prev_sd);
    strobe(8'(POSITION + 7), sd);  check("strobe_ch7", sd, m_hold[7]);
    strobe(8'(POSITION + 0), sd);  check("strobe_ch0", sd, m_hold[0]);
    strobe(8'(POSITION + 1), sd);  check("strobe_ch1_unmasked", sd, m_hold[1]);

    // random mask run
    ebi_write(8'd2, 16'd5);
    model_clear();
    begin
      logic [7:0] rmask;
      logic [2:0] last;
      rmask = 8'($urandom_range(1, 255));
      start_run(rmask);
      base = m_frames;
      wait_frames(base + 6, "wait_rand_frames");
      ebi_write(8'd2, 16'd2);
      repeat (30) @(negedge clk);
      check("rand_frame_count", 32'(got_q.size()), 32'd6);
      last = 3'd7;
      for (int i = 0; i < 6; i++) begin
        last = next_set(rmask, last);
        exp_q.push_back(last);
      end
      while (exp_q.size() > 0 && got_q.size() > 0)
        check("rand_channel", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
        strobe(8'(POSITION + i), sd);
        check($sformatf("rand_hold%0d", i), sd, m_hold[i]);
      end
      ebi_read(8'd4, rd);  check("rand_frame_count_reg", 32'(rd), 32'd6);
    end

    // RESET command mid-SHIFT
    start_run(8'hFF);
    base = m_frames;
    wait_frames(base + 3, "wait_ff_frames");
    wait_rise(7, "wait_bit7");
    @(negedge clk);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = {3'b000, 8'(POSITION), 8'd2}; bus.ebi_data_in = 16'd5;
    @(posedge clk) #1 check("cs_n_low_before_reset_cmd", 32'(adc_cs_n), 32'd0);
    @(negedge clk);
    bus.cs = 1'b0; bus.wr = 1'b0;
    @(posedge clk) #1;
    check("reset_cmd_cs_n", 32'(adc_cs_n), 32'd1);
    check("reset_cmd_sclk", 32'(adc_sclk), 32'd1);
    check("reset_cmd_fsm_idle", 32'(fsm_state), 32'd0);
    model_clear();
    m_mask = '0;
    ebi_read(8'd3, rd);  check("reset_cmd_status", 32'(rd), 32'd0);
    ebi_read(8'd4, rd);  check("reset_cmd_frame_count", 32'(rd), 32'd0);
    ebi_read(8'd1, rd);  check("reset_cmd_mask", 32'(rd), 32'd0);
    for (int i = 0; i < 8; i++) begin
      strobe(8'(POSITION + i), sd);
      check($sformatf("reset_cmd_hold%0d", i), sd, 32'd0);
    end

    // asynchronous reset mid-frame
    fix_code_en = 1'b1; fix_code = 12'hABC;
    start_run(8'h01);
    base = m_frames;
    wait_frames(base + 2, "wait_async_frames");
    strobe(8'(POSITION), sd);  check("async_pre_hold0", sd, 32'h0001_0ABC);
    wait_rise(5, "wait_async_bit5");
    #2 rst = 1'b0;
    #1;
    check("async_cs_n", 32'(adc_cs_n), 32'd1);
    check("async_sclk", 32'(adc_sclk), 32'd1);
    check("async_mosi", 32'(adc_mosi), 32'd0);
    check("async_sample_data", bus.sample_data, 32'd0);
    check("async_ebi_out", 32'(bus.ebi_data_out), 32'd0);
    check("async_fsm_idle", 32'(fsm_state), 32'd0);
    @(negedge clk) rst = 1'b1;
    model_clear();
    ebi_read(8'd3, rd);  check("async_status", 32'(rd), 32'd0);
    strobe(8'(POSITION), sd);  check("async_hold0", sd, 32'd0);

    check("ctrl_word_format", 32'(m_ctrl_bad), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
